serial_add_sub: RTL and testbench

Bit-serial 2's-complement adder/subtractor. Each clock it pushes one bit pair through a single 1-bit full-adder cell, LSB first, and completes a WIDTH-bit result in WIDTH cycles. It sits beside the ALU as the area-minimal arithmetic path for the multi-cycle datapath. It consumes the cell's sum and carry every cycle and returns a registered result with a done pulse.

---
 rtl/serial_add_sub_pkg.sv | 10 +
 rtl/serial_add_sub_full_adder.sv | 11 +
 rtl/serial_add_sub.sv | 97 +++++++++
 tb/tb_serial_add_sub.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/serial_add_sub_pkg.sv
// serial_add_sub_pkg: shared width default and FSM state encoding for the bit-serial adder/subtractor
package serial_add_sub_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = $clog2(DEF_WIDTH);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;
endpackage

// File: rtl/serial_add_sub_full_adder.sv
// serial_add_sub_full_adder: 1-bit full-adder cell
module serial_add_sub_full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial 2's-complement add/sub, LSB first, one bit per clock; SERIAL_ADD_OVF_EN adds o_ovf
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_sna,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_y,
  output logic             o_co
`ifdef SERIAL_ADD_OVF_EN
  , output logic           o_ovf
`endif
);
  localparam int CW = $clog2(WIDTH);
  state_t           r_state;
  logic [WIDTH-1:0] r_sa, r_sb, r_sr, r_y;
  logic [CW-1:0]    r_cnt;
  logic             r_c, r_co, r_busy, r_done;
  logic             w_sum, w_cout, w_last;
  logic [WIDTH-1:0] w_sr_nxt;
`ifdef SERIAL_ADD_OVF_EN
  logic             r_ovf;
  assign o_ovf = r_ovf;
`endif
  serial_add_sub_full_adder u_fa (
    .i_a (r_sa[0]),
    .i_b (r_sb[0]),
    .i_c (r_c),
    .o_s (w_sum),
    .o_c (w_cout)
  );
  assign w_sr_nxt = {w_sum, r_sr[WIDTH-1:1]};
  assign w_last   = r_cnt == CW'(WIDTH - 1);
  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_y      = r_y;
  assign o_co     = r_co;
  // FSM: load on START when idle/finished, shift one bit per RUN cycle, publish result on the last bit
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_sr    <= '0;
      r_y     <= '0;
      r_cnt   <= '0;
      r_c     <= 1'b0;
      r_co    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_RUN: begin
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_sr  <= w_sr_nxt;
          r_c   <= w_cout;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_y     <= w_sr_nxt;
            r_co    <= w_cout;
`ifdef SERIAL_ADD_OVF_EN
            // r_c here is the carry into the MSB
            r_ovf   <= r_c ^ w_cout;
`endif
            r_state <= S_FIN;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          if (i_start) begin
            r_sa    <= i_a;
            r_sb    <= i_sna ? ~i_b : i_b;
            r_c     <= i_sna;
            r_cnt   <= '0;
            r_state <= S_RUN;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: directed scoreboard bench for serial_add_sub (WIDTH=32); OVF checks when SERIAL_ADD_OVF_EN is defined
module tb_serial_add_sub;
  localparam int W = 32;
  typedef struct {
    logic [W-1:0] y;
    logic         co;
    logic         ovf;
  } exp_t;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sna = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, co;
  logic [W-1:0] y;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif
  exp_t         sb[$];
  int           passed = 0;
  int           total = 0;
  int           lat;
  serial_add_sub #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_sna   (sna),
    .i_a     (a),
    .i_b     (b),
    .o_busy  (busy),
    .o_done  (done),
    .o_y     (y),
    .o_co    (co)
`ifdef SERIAL_ADD_OVF_EN
    , .o_ovf (ovf)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  function automatic exp_t model(input logic [W-1:0] ea, input logic [W-1:0] eb, input logic s);
    exp_t         e;
    logic [W:0]   full;
    logic [W-1:0] bb;
    logic [W-1:0] low;
    bb     = s ? ~eb : eb;
    full   = {1'b0, ea} + {1'b0, bb} + {{W{1'b0}}, s};
    low    = {1'b0, ea[W-2:0]} + {1'b0, bb[W-2:0]} + {{(W-1){1'b0}}, s};
    e.y    = full[W-1:0];
    e.co   = full[W];
    e.ovf  = low[W-1] ^ full[W];
    return e;
  endfunction
  // drive one START cycle; expectation is queued as the request is presented
  task automatic go(input logic [W-1:0] ga, input logic [W-1:0] gb, input logic gs);
    @(negedge clk);
    a = ga;
    b = gb;
    sna = gs;
    start = 1'b1;
    sb.push_back(model(ga, gb, gs));
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  // called just after the START edge; counts edges from it (inclusive) to the DONE cycle
  task automatic wait_done(input string tag, output int l);
    logic [W-1:0] y0;
    logic         y_moved, both;
    exp_t         e;
    y0 = y;
    y_moved = 1'b0;
    both = 1'b0;
    l = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (busy && done) both = 1'b1;
      if (done) begin
        l = k;
        break;
      end
      if (y !== y0) y_moved = 1'b1;
    end
    chk({tag, "_lat"}, l, W + 1);
    chk({tag, "_yhold"}, y_moved, 0);
    chk({tag, "_busy_done"}, both, 0);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_y"}, y, e.y);
      chk({tag, "_co"}, co, e.co);
`ifdef SERIAL_ADD_OVF_EN
      chk({tag, "_ovf"}, ovf, e.ovf);
`endif
    end
  endtask
  initial begin
    // reset with random inputs
    a = $urandom;
    b = $urandom;
    sna = 1'($urandom_range(1));
    start = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_y", y, 0);
    chk("rst_co", co, 0);
`ifdef SERIAL_ADD_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    start = 1'b0;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_y", y, 0);
    // directed add/sub cases
    go(32'd5, 32'd7, 1'b0);
    wait_done("add_5_7", lat);
    chk("add_5_7_const", y, 32'h0000000C);
    go(32'hFFFFFFFF, 32'd1, 1'b0);
    wait_done("add_wrap", lat);
    chk("add_wrap_co", co, 1);
    go(32'd3, 32'd5, 1'b1);
    wait_done("sub_3_5", lat);
    chk("sub_3_5_const", y, 32'hFFFFFFFE);
    go(32'd5, 32'd3, 1'b1);
    wait_done("sub_5_3", lat);
    chk("sub_5_3_co", co, 1);
    go(32'h80000000, 32'd1, 1'b1);
    wait_done("sub_minint", lat);
    chk("sub_minint_const", y, 32'h7FFFFFFF);
    go(32'h7FFFFFFF, 32'd1, 1'b0);
    wait_done("add_maxint", lat);
    chk("add_maxint_const", y, 32'h80000000);
`ifdef SERIAL_ADD_OVF_EN
    chk("add_maxint_ovf1", ovf, 1);
`endif
    // START mid-RUN is ignored
    go(32'd10, 32'd20, 1'b0);
    repeat (5) @(negedge clk);
    a = 32'd99;
    b = 32'd1;
    sna = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrun_busy", busy, 1);
    for (int k = 0; k < 40 && !done; k++) @(negedge clk);
    chk("midrun_y", y, 32'd30);
    sb.delete();
    @(negedge clk);
    chk("midrun_no_second", busy, 0);
    // back-to-back: START held through FIN
    @(negedge clk);
    a = 32'd100;
    b = 32'd23;
    sna = 1'b0;
    start = 1'b1;
    sb.push_back(model(32'd100, 32'd23, 1'b0));
    @(posedge clk);
    wait_done("b2b_first", lat);
    a = 32'd50;
    b = 32'd8;
    sna = 1'b1;
    sb.push_back(model(32'd50, 32'd8, 1'b1));
    @(posedge clk);
    #1 start = 1'b0;
    chk("b2b_accept_busy", busy, 1);
    wait_done("b2b_second", lat);
    chk("b2b_second_const", y, 32'd42);
    // asynchronous reset mid-RUN
    go(32'h0000AAAA, 32'h00001111, 1'b0);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_y", y, 0);
    chk("arst_co", co, 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    go(32'd1, 32'd1, 1'b0);
    wait_done("after_rst", lat);
    chk("after_rst_const", y, 32'd2);
    // a few random operations through the scoreboard
    for (int i = 0; i < 4; i++) begin
      go($urandom, $urandom, 1'($urandom_range(1)));
      wait_done("rand", lat);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
